memwb_stage: RTL and testbench

Memory stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline. Consumes the EX/MEM latch outputs, runs the data-memory load/store handshake against the data cache and stalls the pipeline until `dhit`. Resolves the writeback value and registers it for the WB stage. Also owns the sticky halt and a saturating memory-stall counter.

---
 rtl/memwb_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_memwb_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_stage.sv
// ============================================================================
// memwb_stage
// ----------------------------------------------------------------------------
// Memory stage plus the MEM/WB pipeline register of the 5-stage MIPS pipeline.
// Drives the data-cache load/store handshake from the EX/MEM latch outputs,
// stalls the pipeline until the cache answers with dhit, resolves the
// writeback value and registers it for the WB stage. Also owns the sticky
// halt flag and a saturating count of memory-stall cycles.
//
// Optional feature macro: MEMWB_LLSC_EN
//   defined   : LL/SC link register; a failed SC makes no store and writes 0.
//   undefined : no link register; LL is a plain load, SC always stores and
//               always writes 1.
//
// Ports
//   CLK, nRST              clock (rising edge), async active-low reset
//   valid_in               EX/MEM holds a real instruction (0 = bubble)
//   dREN_in, dWEN_in       load / store request (never both)
//   ll_in, sc_in           LL (with dREN_in) / SC (with dWEN_in)
//   dmemaddr_in            effective address (word aligned)
//   dmemstore_in           store data
//   port_o_in              ALU result
//   lui_word_in            LUI immediate word
//   npc_in                 PC+4
//   wdatsel_in             writeback select: 0 ALU, 1 load, 2 LUI, 3 NPC
//   wsel_in, WEN_in        destination register / register write enable
//   halt_in                HALT instruction
//   dmemREN, dmemWEN       data-cache request strobes (combinational)
//   dmemaddr, dmemstore    data-cache address / store data (combinational)
//   dhit, dmemload         cache completion / load data (same cycle)
//   mem_stall              freezes PC, IF/ID, ID/EX and EX/MEM
//   valid_out, WEN_out     registered writeback controls
//   wsel_out, wdat_out     registered destination / writeback data
//   halt_out               sticky halt, to the system
//   stall_cnt              saturating count of memory-stall cycles
// ============================================================================
module memwb_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        valid_in,
    input  logic        dREN_in,
    input  logic        dWEN_in,
    input  logic        ll_in,
    input  logic        sc_in,
    input  logic [31:0] dmemaddr_in,
    input  logic [31:0] dmemstore_in,
    input  logic [31:0] port_o_in,
    input  logic [31:0] lui_word_in,
    input  logic [31:0] npc_in,
    input  logic [1:0]  wdatsel_in,
    input  logic [4:0]  wsel_in,
    input  logic        WEN_in,
    input  logic        halt_in,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        mem_stall,
    output logic        valid_out,
    output logic        WEN_out,
    output logic [4:0]  wsel_out,
    output logic [31:0] wdat_out,
    output logic        halt_out,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic        wen_q, wen_d;
    logic [4:0]  wsel_q, wsel_d;
    logic [31:0] wdat_q, wdat_d;
    logic        halt_q, halt_d;
    logic [15:0] cnt_q, cnt_d;

    logic        active_s;
    logic        mem_op_s;
    logic        sc_s;
    logic        sc_fail_s;
    logic        ren_s;
    logic        wen_req_s;
    logic        stall_s;
    logic        complete_s;
    logic [31:0] sel_dat_s;

`ifdef MEMWB_LLSC_EN
    logic        link_valid_q, link_valid_d;
    logic [31:0] link_addr_q, link_addr_d;

    // An SC fails unless the link is valid and points at the same word.
    always_comb begin
        sc_fail_s = sc_s & ~(link_valid_q & (link_addr_q == dmemaddr_in));
    end
`else
    // Without the link register LL is an ordinary load and SC never fails.
    logic unused_ll_s;
    assign unused_ll_s = ll_in;

    // SC failure is impossible in this build.
    always_comb begin
        sc_fail_s = 1'b0;
    end
`endif

    // Request path: combinational from the EX/MEM inputs; reset and the
    // halted state both drop the request immediately.
    always_comb begin
        active_s   = nRST & (state_q != HALTED);
        mem_op_s   = active_s & valid_in & (dREN_in | dWEN_in);
        sc_s       = sc_in & dWEN_in;
        ren_s      = mem_op_s & dREN_in;
        wen_req_s  = mem_op_s & dWEN_in & ~sc_fail_s;
        stall_s    = (ren_s | wen_req_s) & ~dhit;
        // A failed SC issues no request, so it completes without dhit.
        complete_s = active_s & valid_in & (~mem_op_s | dhit | sc_fail_s);
        dmemREN    = ren_s;
        dmemWEN    = wen_req_s;
        dmemaddr   = dmemaddr_in;
        dmemstore  = dmemstore_in;
        mem_stall  = stall_s;
    end

    // Writeback data select; SC replaces the value with its success flag.
    always_comb begin
        sel_dat_s = port_o_in;
        case (wdatsel_in)
            2'd0:    sel_dat_s = port_o_in;
            2'd1:    sel_dat_s = dmemload;
            2'd2:    sel_dat_s = lui_word_in;
            2'd3:    sel_dat_s = npc_in;
            default: sel_dat_s = port_o_in;
        endcase
        if (sc_s) begin
            sel_dat_s = sc_fail_s ? 32'd0 : 32'd1;
        end else begin
            sel_dat_s = sel_dat_s;
        end
    end

    // Next-state and MEM/WB register next values.
    always_comb begin
        state_d = state_q;
        valid_d = complete_s;
        wen_d   = complete_s & WEN_in;
        wsel_d  = wsel_q;
        wdat_d  = wdat_q;
        halt_d  = halt_q | (complete_s & halt_in);
        cnt_d   = cnt_q;

        if (complete_s) begin
            wsel_d = wsel_in;
            wdat_d = sel_dat_s;
        end else begin
            wsel_d = wsel_q;
            wdat_d = wdat_q;
        end

        if (stall_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            RUN, WAIT: begin
                if (complete_s && halt_in) begin
                    state_d = HALTED;
                end else if (stall_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

`ifdef MEMWB_LLSC_EN
    // Link register update: LL sets it, any SC clears it, and a completed
    // store to the linked word clears it.
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (complete_s && ll_in && dREN_in) begin
            link_valid_d = 1'b1;
            link_addr_d  = dmemaddr_in;
        end else if (complete_s && sc_s) begin
            link_valid_d = 1'b0;
        end else if (complete_s && dWEN_in && (dmemaddr_in == link_addr_q)) begin
            link_valid_d = 1'b0;
        end else begin
            link_valid_d = link_valid_q;
        end
    end

    // Link register flops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= 32'd0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end
`endif

    // State, MEM/WB register, halt flag and stall counter flops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            wsel_q  <= 5'd0;
            wdat_q  <= 32'd0;
            halt_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            wen_q   <= wen_d;
            wsel_q  <= wsel_d;
            wdat_q  <= wdat_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_out = valid_q;
    assign WEN_out   = wen_q;
    assign wsel_out  = wsel_q;
    assign wdat_out  = wdat_q;
    assign halt_out  = halt_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        valid_in, dREN_in, dWEN_in, ll_in, sc_in;
    logic [31:0] dmemaddr_in, dmemstore_in, port_o_in, lui_word_in, npc_in;
    logic [1:0]  wdatsel_in;
    logic [4:0]  wsel_in;
    logic        WEN_in, halt_in;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        mem_stall, valid_out, WEN_out;
    logic [4:0]  wsel_out;
    logic [31:0] wdat_out;
    logic        halt_out;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    memwb_stage dut (
        .CLK(CLK), .nRST(nRST), .valid_in(valid_in), .dREN_in(dREN_in),
        .dWEN_in(dWEN_in), .ll_in(ll_in), .sc_in(sc_in),
        .dmemaddr_in(dmemaddr_in), .dmemstore_in(dmemstore_in),
        .port_o_in(port_o_in), .lui_word_in(lui_word_in), .npc_in(npc_in),
        .wdatsel_in(wdatsel_in), .wsel_in(wsel_in), .WEN_in(WEN_in),
        .halt_in(halt_in), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
        .dmemload(dmemload), .mem_stall(mem_stall), .valid_out(valid_out),
        .WEN_out(WEN_out), .wsel_out(wsel_out), .wdat_out(wdat_out),
        .halt_out(halt_out), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid, ren, wen, ll, sc, halt, dhit;
        logic [31:0] addr, store, load, alu;
        logic [1:0]  wdatsel;
        logic [4:0]  wsel;
        logic        wen_rf;
        logic        e_ren, e_wen, e_stall, e_valid, e_wenout;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdat;
        logic        e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    localparam logic [31:0] LUI_W = 32'hABCD0000;
    localparam logic [31:0] NPC_W = 32'h00000404;

    function automatic vec_t mk(
        input logic v, r, w, l, s, h, d,
        input logic [31:0] a, st, ld, al,
        input logic [1:0] ws, input logic [4:0] sel, input logic rf,
        input logic er, ew, es, ev, ewo, input logic [4:0] esel,
        input logic [31:0] ed, input logic eh, input logic [15:0] ec);
        vec_t x;
        x.valid = v; x.ren = r; x.wen = w; x.ll = l; x.sc = s; x.halt = h;
        x.dhit = d; x.addr = a; x.store = st; x.load = ld; x.alu = al;
        x.wdatsel = ws; x.wsel = sel; x.wen_rf = rf;
        x.e_ren = er; x.e_wen = ew; x.e_stall = es; x.e_valid = ev;
        x.e_wenout = ewo; x.e_wsel = esel; x.e_wdat = ed; x.e_halt = eh;
        x.e_cnt = ec;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0; ll_in = 1'b0;
        sc_in = 1'b0; halt_in = 1'b0; dhit = 1'b0; dmemaddr_in = 32'd0;
        dmemstore_in = 32'd0; dmemload = 32'd0; port_o_in = 32'd0;
        wdatsel_in = 2'd0; wsel_in = 5'd0; WEN_in = 1'b0;
        lui_word_in = LUI_W; npc_in = NPC_W;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        valid_in = v.valid; dREN_in = v.ren; dWEN_in = v.wen; ll_in = v.ll;
        sc_in = v.sc; halt_in = v.halt; dhit = v.dhit; dmemaddr_in = v.addr;
        dmemstore_in = v.store; dmemload = v.load; port_o_in = v.alu;
        wdatsel_in = v.wdatsel; wsel_in = v.wsel; WEN_in = v.wen_rf;
    endtask

    // One cycle: drive at negedge, check request path, then check MEM/WB after the edge.
    task automatic do_cycle(input string tag, input vec_t v);
        @(negedge CLK);
        drive(v);
        #1;
        check({tag, ".dmemREN"}, {31'd0, dmemREN}, {31'd0, v.e_ren});
        check({tag, ".dmemWEN"}, {31'd0, dmemWEN}, {31'd0, v.e_wen});
        check({tag, ".mem_stall"}, {31'd0, mem_stall}, {31'd0, v.e_stall});
        check({tag, ".dmemaddr"}, dmemaddr, v.addr);
        check({tag, ".dmemstore"}, dmemstore, v.store);
        @(posedge CLK);
        #1;
        check({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, v.e_valid});
        check({tag, ".WEN_out"}, {31'd0, WEN_out}, {31'd0, v.e_wenout});
        check({tag, ".wsel_out"}, {27'd0, wsel_out}, {27'd0, v.e_wsel});
        check({tag, ".wdat_out"}, wdat_out, v.e_wdat);
        check({tag, ".halt_out"}, {31'd0, halt_out}, {31'd0, v.e_halt});
        check({tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, v.e_cnt});
    endtask

    vec_t tbl[7];

    initial begin
        //             v  r  w  l  s  h  d  addr          store         load          alu           ws    sel    rf   er ew es ev ewo esel   edat          eh ec
        tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h00001234, 2'd0, 5'd5,  1,   0, 0, 0, 1, 1,  5'd5,  32'h00001234, 0, 16'd0);
        tbl[1] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h00000011, 2'd2, 5'd7,  1,   0, 0, 0, 1, 1,  5'd7,  LUI_W,        0, 16'd0);
        tbl[2] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h00000022, 2'd3, 5'd31, 1,   0, 0, 0, 1, 1,  5'd31, NPC_W,        0, 16'd0);
        tbl[3] = mk(1, 1, 0, 0, 0, 0, 1, 32'h00000080, 32'h0,        32'h55AA55AA, 32'h00000080, 2'd1, 5'd9,  1,   1, 0, 0, 1, 1,  5'd9,  32'h55AA55AA, 0, 16'd0);
        tbl[4] = mk(1, 0, 1, 0, 0, 0, 1, 32'h00000200, 32'hCAFEF00D, 32'h0,        32'h00000200, 2'd0, 5'd3,  0,   0, 1, 0, 1, 0,  5'd3,  32'h00000200, 0, 16'd0);
        tbl[5] = mk(0, 1, 0, 0, 0, 0, 0, 32'h00000300, 32'h0,        32'h0,        32'h00000099, 2'd0, 5'd12, 1,   0, 0, 0, 0, 0,  5'd3,  32'h00000200, 0, 16'd0);
        tbl[6] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h00000007, 2'd0, 5'd0,  0,   0, 0, 0, 1, 0,  5'd0,  32'h00000007, 0, 16'd0);

        idle_inputs();
        nRST = 1'b0;
        #12;
        check("rst.valid_out", {31'd0, valid_out}, 32'd0);
        check("rst.WEN_out", {31'd0, WEN_out}, 32'd0);
        check("rst.wsel_out", {27'd0, wsel_out}, 32'd0);
        check("rst.wdat_out", wdat_out, 32'd0);
        check("rst.halt_out", {31'd0, halt_out}, 32'd0);
        check("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_cycle($sformatf("tbl%0d", i), tbl[i]);
        end

        // LW at 0x100 with three miss cycles.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            do_cycle($sformatf("lwmiss%0d", i),
                mk(1, 1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h100, 2'd1, 5'd8, 1,
                   1, 0, 1, 0, 0, 5'd0, 32'h0, 0, 16'(i)));
        end
        do_cycle("lwhit", mk(1, 1, 0, 0, 0, 0, 1, 32'h100, 32'h0, 32'hDEADBEEF, 32'h100, 2'd1, 5'd8, 1,
                             1, 0, 0, 1, 1, 5'd8, 32'hDEADBEEF, 0, 16'd3));

        // Reset pulsed while waiting on the cache.
        do_reset();
        for (int i = 1; i <= 2; i++) begin
            do_cycle($sformatf("wmiss%0d", i),
                mk(1, 1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h100, 2'd1, 5'd8, 1,
                   1, 0, 1, 0, 0, 5'd0, 32'h0, 0, 16'(i)));
        end
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check("wrst.dmemREN", {31'd0, dmemREN}, 32'd0);
        check("wrst.mem_stall", {31'd0, mem_stall}, 32'd0);
        check("wrst.valid_out", {31'd0, valid_out}, 32'd0);
        check("wrst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge CLK);
        idle_inputs();
        nRST = 1'b1;
        do_cycle("wrst.add", tbl[0]);

        // HALT riding on a pending LW.
        do_reset();
        for (int i = 1; i <= 2; i++) begin
            do_cycle($sformatf("hmiss%0d", i),
                mk(1, 1, 0, 0, 0, 1, 0, 32'h100, 32'h0, 32'h0, 32'h100, 2'd1, 5'd8, 1,
                   1, 0, 1, 0, 0, 5'd0, 32'h0, 0, 16'(i)));
        end
        do_cycle("hhit", mk(1, 1, 0, 0, 0, 1, 1, 32'h100, 32'h0, 32'h0BADF00D, 32'h100, 2'd1, 5'd8, 1,
                            1, 0, 0, 1, 1, 5'd8, 32'h0BADF00D, 1, 16'd2));
        do_cycle("hlw", mk(1, 1, 0, 0, 0, 0, 0, 32'h104, 32'h0, 32'h0, 32'h104, 2'd1, 5'd9, 1,
                           0, 0, 0, 0, 0, 5'd8, 32'h0BADF00D, 1, 16'd2));
        do_cycle("hsw", mk(1, 0, 1, 0, 0, 0, 1, 32'h108, 32'h5, 32'h0, 32'h108, 2'd0, 5'd0, 0,
                           0, 0, 0, 0, 0, 5'd8, 32'h0BADF00D, 1, 16'd2));
        do_cycle("hadd", mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h77, 2'd0, 5'd5, 1,
                            0, 0, 0, 0, 0, 5'd8, 32'h0BADF00D, 1, 16'd2));

        // LL / SC.
        do_reset();
`ifdef MEMWB_LLSC_EN
        do_cycle("ll1", mk(1, 1, 0, 1, 0, 0, 1, 32'h300, 32'h0, 32'h11, 32'h300, 2'd1, 5'd4, 1,
                           1, 0, 0, 1, 1, 5'd4, 32'h11, 0, 16'd0));
        do_cycle("sc_ok", mk(1, 0, 1, 0, 1, 0, 1, 32'h300, 32'h22, 32'h0, 32'h300, 2'd0, 5'd4, 1,
                             0, 1, 0, 1, 1, 5'd4, 32'h1, 0, 16'd0));
        do_cycle("ll2", mk(1, 1, 0, 1, 0, 0, 1, 32'h300, 32'h0, 32'h11, 32'h300, 2'd1, 5'd4, 1,
                           1, 0, 0, 1, 1, 5'd4, 32'h11, 0, 16'd0));
        do_cycle("sw_kill", mk(1, 0, 1, 0, 0, 0, 1, 32'h300, 32'h33, 32'h0, 32'h300, 2'd0, 5'd0, 0,
                               0, 1, 0, 1, 0, 5'd0, 32'h300, 0, 16'd0));
        do_cycle("sc_fail", mk(1, 0, 1, 0, 1, 0, 0, 32'h300, 32'h44, 32'h0, 32'h300, 2'd0, 5'd4, 1,
                               0, 0, 0, 1, 1, 5'd4, 32'h0, 0, 16'd0));
`else
        do_cycle("ll1", mk(1, 1, 0, 1, 0, 0, 1, 32'h300, 32'h0, 32'h11, 32'h300, 2'd1, 5'd4, 1,
                           1, 0, 0, 1, 1, 5'd4, 32'h11, 0, 16'd0));
        do_cycle("sc_miss", mk(1, 0, 1, 0, 1, 0, 0, 32'h300, 32'h22, 32'h0, 32'h300, 2'd0, 5'd4, 1,
                               0, 1, 1, 0, 0, 5'd4, 32'h11, 0, 16'd1));
        do_cycle("sc_hit", mk(1, 0, 1, 0, 1, 0, 1, 32'h300, 32'h22, 32'h0, 32'h300, 2'd0, 5'd4, 1,
                              0, 1, 0, 1, 1, 5'd4, 32'h1, 0, 16'd1));
        do_cycle("sc_nolink", mk(1, 0, 1, 0, 1, 0, 1, 32'h500, 32'h66, 32'h0, 32'h500, 2'd0, 5'd6, 1,
                                 0, 1, 0, 1, 1, 5'd6, 32'h1, 0, 16'd1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
